// File: rtl/prog_ram16_8bit_if.sv
// ---------------------------------------------------------------------------
// prog_ram16_8bit_if
//   Control and loader bundle for the 16x8 program RAM.
//   The tri-stated read bus (data_out) is a shared net, so it stays a plain
//   port on the RAM and is not carried in this interface.
//
//   CPU side   : addr, low_o_en, low_we, data_in, prog_mode
//   Loader side: ld_valid, ld_data (to RAM); ld_ready, ld_done, ld_count,
//                ld_sum (from RAM)
//
//   Modports: master = CPU/loader driver, slave = the RAM.
// ---------------------------------------------------------------------------
interface prog_ram16_8bit_if #(
  parameter int WIDTH = 8
) ();
  logic [3:0]       addr;
  logic             low_o_en;
  logic             low_we;
  logic [WIDTH-1:0] data_in;
  logic             prog_mode;
  logic             ld_valid;
  logic [WIDTH-1:0] ld_data;
  logic             ld_ready;
  logic             ld_done;
  logic [4:0]       ld_count;
  logic [WIDTH-1:0] ld_sum;

  modport master (
    output addr, low_o_en, low_we, data_in, prog_mode, ld_valid, ld_data,
    input  ld_ready, ld_done, ld_count, ld_sum
  );

  modport slave (
    input  addr, low_o_en, low_we, data_in, prog_mode, ld_valid, ld_data,
    output ld_ready, ld_done, ld_count, ld_sum
  );
endinterface

// File: rtl/prog_ram16_8bit.sv
// ---------------------------------------------------------------------------
// prog_ram16_8bit
//   16x8 writable program store. The CPU reads it combinationally onto a
//   tri-stated bus and may write it with store instructions in run mode.
//   While prog_mode=1 a sequential loader streams a 16-byte image into
//   addresses 0x0..0xF over a valid/ready handshake.
//
//   Ports:
//     clk       rising-edge clock
//     low_rst   asynchronous active-low reset (clears memory and loader)
//     bus       prog_ram16_8bit_if.slave (CPU controls + loader handshake)
//     data_out  read bus, high-Z when low_o_en=1 or prog_mode=1
//
//   Build option:
//     LOADER_CHECKSUM_EN  when defined, ld_sum is the modulo-256 sum of the
//                         bytes accepted in the current load; otherwise
//                         ld_sum is tied to zero and no accumulator exists.
// ---------------------------------------------------------------------------
module prog_ram16_8bit #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                low_rst,
  prog_ram16_8bit_if.slave    bus,
  output logic [WIDTH-1:0]    data_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 5;
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ld_ready_q;
  logic             ld_done_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    ld_count_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             xfer;
  logic             load_start;

  // The loader only owns the array while prog_mode is high, so a LOAD cycle
  // in which prog_mode has just dropped cannot collide with a CPU store.
  assign xfer       = ld_ready_q && bus.ld_valid && bus.prog_mode;
  assign load_start = (state_q != LOAD) && (state_d == LOAD);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.prog_mode) state_d = LOAD;
      LOAD: begin
        if (!bus.prog_mode)                    state_d = IDLE;
        else if (xfer && ld_count_q == LAST_CNT) state_d = DONE;
      end
      DONE: if (!bus.prog_mode) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ld_ready/ld_done are flops loaded from the next state, so they never
  // depend combinationally on ld_valid.
  always_ff @(posedge clk or negedge low_rst) begin
    if (!low_rst) begin
      state_q    <= IDLE;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_ready_q <= (state_d == LOAD);
      ld_done_q  <= (state_d == DONE);
    end
  end

  // Write pointer and accepted-byte count restart on every LOAD entry; the
  // count otherwise holds so software can inspect a partial load.
  always_ff @(posedge clk or negedge low_rst) begin
    if (!low_rst) begin
      wr_ptr_q   <= '0;
      ld_count_q <= '0;
    end else if (load_start) begin
      wr_ptr_q   <= '0;
      ld_count_q <= '0;
    end else if (xfer) begin
      wr_ptr_q   <= wr_ptr_q + 1'b1;
      ld_count_q <= ld_count_q + 1'b1;
    end
  end

  // Loader and CPU writes are mutually exclusive through prog_mode.
  always_ff @(posedge clk or negedge low_rst) begin
    if (!low_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (xfer) begin
      mem[wr_ptr_q] <= bus.ld_data;
    end else if (!bus.prog_mode && !bus.low_we) begin
      mem[bus.addr] <= bus.data_in;
    end
  end

  assign data_out = (!bus.low_o_en && !bus.prog_mode) ? mem[bus.addr]
                                                      : {WIDTH{1'bz}};

`ifdef LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] ld_sum_q;

  always_ff @(posedge clk or negedge low_rst) begin
    if (!low_rst)        ld_sum_q <= '0;
    else if (load_start) ld_sum_q <= '0;
    else if (xfer)       ld_sum_q <= ld_sum_q + bus.ld_data;
  end

  assign bus.ld_sum = ld_sum_q;
`else
  assign bus.ld_sum = '0;
`endif

  assign bus.ld_ready = ld_ready_q;
  assign bus.ld_done  = ld_done_q;
  assign bus.ld_count = ld_count_q;

endmodule

// File: tb/tb_prog_ram16_8bit.sv
// ---------------------------------------------------------------------------
// tb_prog_ram16_8bit
//   Directed bench for prog_ram16_8bit. The read bus is a pulled-up net, so
//   a released (high-Z) bus reads back as 8'hFF.
// ---------------------------------------------------------------------------
module tb_prog_ram16_8bit;

  logic clk = 1'b0;
  logic low_rst;
  tri1 [7:0] data_out_w;

  prog_ram16_8bit_if #(.WIDTH(8)) bus ();

  prog_ram16_8bit #(.DEPTH(16), .WIDTH(8)) dut (
    .clk      (clk),
    .low_rst  (low_rst),
    .bus      (bus),
    .data_out (data_out_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic       oe_n;
    logic       pm;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t    rv [22];
  logic [7:0] img [16];
  int         total = 0;
  int         bad   = 0;
  int         rdy_cycles;
  logic [7:0] exp_sum;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rows are applied 1 ns apart right after an edge; at most 7 rows per call
  // so no clock edge falls inside a call.
  task automatic apply_reads(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.addr      = rv[i].addr;
      bus.low_o_en  = rv[i].oe_n;
      bus.prog_mode = rv[i].pm;
      #1;
      check($sformatf("read[%0d]", i), data_out_w, rv[i].exp);
    end
    bus.prog_mode = 1'b0;
    bus.low_o_en  = 1'b1;
  endtask

  task automatic load_bytes(input int n, input bit gaps, output int rc);
    int   idx;
    int   cyc;
    bit   phase;
    logic rdy;
    idx = 0; cyc = 0; phase = 1'b1; rc = 0;
    while (idx < n && cyc < 200) begin
      bus.ld_valid = gaps ? phase : 1'b1;
      bus.ld_data  = img[idx];
      rdy = bus.ld_ready;
      if (rdy) rc++;
      tick();
      if (rdy && bus.ld_valid) idx++;
      phase = ~phase;
      cyc++;
    end
    bus.ld_valid = 1'b0;
    if (cyc >= 200) check("load_timeout", idx, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // read-vector table: {addr, low_o_en, prog_mode, expected data_out}
    rv[0]  = '{4'h5, 1'b0, 1'b0, 8'h00};
    rv[1]  = '{4'h5, 1'b1, 1'b0, 8'hFF};
    rv[2]  = '{4'h1, 1'b0, 1'b0, 8'h59};
    rv[3]  = '{4'h9, 1'b0, 1'b0, 8'h06};
    rv[4]  = '{4'h8, 1'b0, 1'b0, 8'h07};
    rv[5]  = '{4'h0, 1'b0, 1'b0, 8'h08};
    rv[6]  = '{4'h2, 1'b0, 1'b1, 8'hFF};
    rv[7]  = '{4'h2, 1'b0, 1'b0, 8'hEE};
    rv[8]  = '{4'h0, 1'b0, 1'b0, 8'h08};
    rv[9]  = '{4'h5, 1'b0, 1'b0, 8'h35};
    rv[10] = '{4'hF, 1'b0, 1'b0, 8'h3F};
    rv[11] = '{4'h1, 1'b0, 1'b0, 8'h31};
    rv[12] = '{4'h0, 1'b0, 1'b0, 8'h11};
    rv[13] = '{4'h1, 1'b0, 1'b0, 8'h12};
    rv[14] = '{4'h2, 1'b0, 1'b0, 8'h13};
    rv[15] = '{4'h3, 1'b0, 1'b0, 8'h14};
    rv[16] = '{4'h4, 1'b0, 1'b0, 8'h15};
    rv[17] = '{4'h5, 1'b0, 1'b0, 8'h35};
    rv[18] = '{4'hF, 1'b0, 1'b0, 8'h3F};
    rv[19] = '{4'h0, 1'b0, 1'b0, 8'h77};
    rv[20] = '{4'h1, 1'b0, 1'b0, 8'h78};
    rv[21] = '{4'h2, 1'b0, 1'b0, 8'h13};

    low_rst       = 1'b0;
    bus.addr      = 4'h0;
    bus.low_o_en  = 1'b1;
    bus.low_we    = 1'b1;
    bus.data_in   = 8'h00;
    bus.prog_mode = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = 8'h00;

    // reset state
    repeat (2) tick();
    check("rst_ld_ready", bus.ld_ready, 1'b0);
    check("rst_ld_done",  bus.ld_done,  1'b0);
    check("rst_ld_count", bus.ld_count, 5'd0);
    check("rst_ld_sum",   bus.ld_sum,   8'h00);
    low_rst = 1'b1;
    tick();
    apply_reads(0, 1);

    // full load, ld_valid held high
    img = '{8'h08, 8'h59, 8'hEE, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h07, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    bus.prog_mode = 1'b1;
    tick();
    load_bytes(16, 1'b0, rdy_cycles);
    check("full_ready_cycles", rdy_cycles, 16);
    check("full_ready_drop",   bus.ld_ready, 1'b0);
    check("full_done",         bus.ld_done,  1'b1);
    check("full_count",        bus.ld_count, 5'd16);
`ifdef LOADER_CHECKSUM_EN
    check("full_sum", bus.ld_sum, 8'h5B);
`else
    check("full_sum", bus.ld_sum, 8'h00);
`endif
    bus.prog_mode = 1'b0;
    tick();
    check("full_done_clr",  bus.ld_done,  1'b0);
    check("full_count_hold", bus.ld_count, 5'd16);
    apply_reads(2, 7);

    // gapped load, then a 17th byte that must be dropped
    img[0] = 8'h08;
    for (int i = 1; i < 16; i++) img[i] = 8'h30 + 8'(i);
    bus.prog_mode = 1'b1;
    tick();
    load_bytes(16, 1'b1, rdy_cycles);
    check("gap_ready_cycles", rdy_cycles, 31);
    check("gap_done",  bus.ld_done,  1'b1);
    check("gap_count", bus.ld_count, 5'd16);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'hAA;
    tick();
    bus.ld_valid = 1'b0;
    check("extra_count", bus.ld_count, 5'd16);
    check("extra_ready", bus.ld_ready, 1'b0);
    bus.prog_mode = 1'b0;
    tick();
    apply_reads(8, 11);

    // aborted partial load, then restart from address 0
    for (int i = 0; i < 5; i++) img[i] = 8'h11 + 8'(i);
    bus.prog_mode = 1'b1;
    tick();
    load_bytes(5, 1'b0, rdy_cycles);
    bus.prog_mode = 1'b0;
    tick();
    check("abort_done",  bus.ld_done,  1'b0);
    check("abort_count", bus.ld_count, 5'd5);
    check("abort_ready", bus.ld_ready, 1'b0);
    apply_reads(12, 18);
    img[0] = 8'h77;
    img[1] = 8'h78;
    bus.prog_mode = 1'b1;
    tick();
    check("restart_count0", bus.ld_count, 5'd0);
    load_bytes(2, 1'b0, rdy_cycles);
    check("restart_count2", bus.ld_count, 5'd2);
    bus.prog_mode = 1'b0;
    tick();
    apply_reads(19, 21);

    // run-mode write, then the same store attempted in program mode
    bus.addr    = 4'hA;
    bus.data_in = 8'h3C;
    bus.low_we  = 1'b0;
    tick();
    bus.low_we   = 1'b1;
    bus.low_o_en = 1'b0;
    #1;
    check("runwr_a", data_out_w, 8'h3C);
    bus.low_o_en  = 1'b1;
    bus.prog_mode = 1'b1;
    bus.data_in   = 8'h55;
    bus.low_we    = 1'b0;
    tick();
    bus.low_we    = 1'b1;
    bus.prog_mode = 1'b0;
    tick();
    bus.low_o_en = 1'b0;
    #1;
    check("progwr_ignored", data_out_w, 8'h3C);
    bus.low_o_en = 1'b1;

    // checksum image 01..10
    for (int i = 0; i < 16; i++) img[i] = 8'(i + 1);
`ifdef LOADER_CHECKSUM_EN
    exp_sum = 8'h88;
`else
    exp_sum = 8'h00;
`endif
    bus.prog_mode = 1'b1;
    tick();
    load_bytes(16, 1'b0, rdy_cycles);
    check("csum_done", bus.ld_done, 1'b1);
    check("csum_sum",  bus.ld_sum,  exp_sum);
    bus.prog_mode = 1'b0;
    tick();
    check("csum_hold", bus.ld_sum, exp_sum);
    bus.addr     = 4'hF;
    bus.low_o_en = 1'b0;
    #1;
    check("csum_memF", data_out_w, 8'h10);
    bus.low_o_en = 1'b1;

    // asynchronous reset in the middle of a load
    bus.prog_mode = 1'b1;
    tick();
    load_bytes(3, 1'b0, rdy_cycles);
    check("midrst_count_pre", bus.ld_count, 5'd3);
    low_rst = 1'b0;
    #1;
    check("midrst_ready", bus.ld_ready, 1'b0);
    check("midrst_count", bus.ld_count, 5'd0);
    check("midrst_sum",   bus.ld_sum,   8'h00);
    bus.prog_mode = 1'b0;
    bus.low_o_en  = 1'b0;
    bus.addr      = 4'h0;
    #1;
    check("midrst_mem0", data_out_w, 8'h00);
    bus.addr = 4'h2;
    #1;
    check("midrst_mem2", data_out_w, 8'h00);
    bus.low_o_en = 1'b1;
    low_rst = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
